// File: rtl/mem_bus_pkg.sv
// Shared encodings and lane helpers for the core-to-bus memory adapter.
package mem_bus_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        FAULT
    } state_t;

    function automatic logic is_illegal(input logic [1:0] width, input logic [1:0] addr_lo);
        case (width)
            WIDTH_BYTE: is_illegal = 1'b0;
            WIDTH_HALF: is_illegal = addr_lo[0];
            WIDTH_WORD: is_illegal = (addr_lo != 2'b00);
            default:    is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] gen_byte_enable(input logic [1:0] width, input logic [1:0] addr_lo);
        case (width)
            WIDTH_BYTE: gen_byte_enable = 4'b0001 << addr_lo;
            WIDTH_HALF: gen_byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
            WIDTH_WORD: gen_byte_enable = 4'b1111;
            default:    gen_byte_enable = 4'b0000;
        endcase
    endfunction

    // Store data is copied into every lane so the byte enables alone select it.
    function automatic logic [31:0] replicate_store(input logic [1:0] width, input logic [31:0] wdata);
        case (width)
            WIDTH_BYTE: replicate_store = {4{wdata[7:0]}};
            WIDTH_HALF: replicate_store = {2{wdata[15:0]}};
            default:    replicate_store = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module mem_load_extend (
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    output logic [31:0] result
);
    import mem_bus_pkg::*;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'd0;
        half_lane = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (addr_lo)
            2'd0:    byte_lane = bus_rdata[7:0];
            2'd1:    byte_lane = bus_rdata[15:8];
            2'd2:    byte_lane = bus_rdata[23:16];
            default: byte_lane = bus_rdata[31:24];
        endcase
    end

    always_comb begin
        result = 32'd0;
        case (width)
            WIDTH_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            WIDTH_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
            WIDTH_WORD: result = bus_rdata;
            default:    result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_bus_adapter.sv
// Converts core byte/half/word load-store requests into a word-addressed
// req/ack bus transaction, with alignment checking and a bus timeout fault.
module mem_bus_adapter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  write,
    input  logic                  sign_ext,
    input  logic [1:0]            width,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-3:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack
);
    import mem_bus_pkg::*;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [1:0]       lane_q;
    logic [1:0]       width_q;
    logic             sign_q;
    logic             illegal;
    logic             timed_out;
    logic [31:0]      load_value;

    assign illegal   = is_illegal(width, addr[1:0]);
    assign timed_out = (count == CNT_LAST);

    // Combinational so the core can stall in the very cycle en rises.
    assign busy = (en && (state == IDLE) && !illegal) || (state == REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = illegal ? FAULT : REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    next_state = DONE;
                end else if (timed_out) begin
                    next_state = FAULT;
                end
            end
            DONE: begin
                if (!en) begin
                    next_state = IDLE;
                end
            end
            default: next_state = FAULT;
        endcase
    end

    // Access attributes are latched at acceptance; the core may drop en mid-REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata     <= 32'd0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            count     <= '0;
            lane_q    <= 2'd0;
            width_q   <= 2'd0;
            sign_q    <= 1'b0;
        end else begin
            if (next_state == FAULT) begin
                fault <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (en && !illegal) begin
                        bus_req   <= 1'b1;
                        bus_we    <= write;
                        bus_addr  <= addr[ADDR_WIDTH-1:2];
                        bus_be    <= gen_byte_enable(width, addr[1:0]);
                        bus_wdata <= replicate_store(width, wdata);
                        count     <= '0;
                        lane_q    <= addr[1:0];
                        width_q   <= width;
                        sign_q    <= sign_ext;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata <= load_value;
                        end
                    end else if (timed_out) begin
                        bus_req <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    mem_load_extend u_load_extend (
        .bus_rdata (bus_rdata),
        .addr_lo   (lane_q),
        .width     (width_q),
        .sign_ext  (sign_q),
        .result    (load_value)
    );

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Scoreboard bench for mem_bus_adapter: stimulus queues expectations, a monitor
// compares bus requests and access completions as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_bus_adapter;
    import mem_bus_pkg::*;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          write = 1'b0;
    logic          sign_ext = 1'b0;
    logic [1:0]    width = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = 32'd0;
    logic [31:0]   rdata;
    logic          busy;
    logic          fault;
    logic          bus_req;
    logic          bus_we;
    logic [AW-3:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata = 32'd0;
    logic          agent_ack = 1'b0;
    logic          stray_ack = 1'b0;
    logic          bus_ack;

    assign bus_ack = agent_ack | stray_ack;

    typedef struct {
        logic          we;
        logic [AW-3:0] baddr;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            req_len;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        flt;
        int          busy_len;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int        compared = 0;
    int        mismatched = 0;
    int        ack_at = 0;

    always #5 clk = ~clk;

    mem_bus_adapter #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .write     (write),
        .sign_ext  (sign_ext),
        .width     (width),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .fault     (fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectBus(input logic we, input logic [AW-3:0] baddr, input logic [3:0] be,
                             input logic [31:0] wd, input int len);
        bus_exp_t item;
        item.we = we;
        item.baddr = baddr;
        item.be = be;
        item.wd = wd;
        item.req_len = len;
        bus_q.push_back(item);
    endtask

    task automatic expectResp(input logic [31:0] rd, input logic flt, input int busy_len);
        resp_exp_t item;
        item.rd = rd;
        item.flt = flt;
        item.busy_len = busy_len;
        resp_q.push_back(item);
    endtask

    task automatic applyStimulus(input logic wr, input logic sx, input logic [1:0] wd,
                                 input logic [31:0] a, input logic [31:0] wdat,
                                 input logic [31:0] brd, input int ack_cycle,
                                 input int hold, input bit drop_early);
        bit done;
        ack_at = ack_cycle;
        bus_rdata = brd;
        @(posedge clk); #1;
        write = wr;
        sign_ext = sx;
        width = wd;
        addr = a;
        wdata = wdat;
        en = 1'b1;
        if (drop_early) begin
            @(posedge clk); #1;
            en = 1'b0;
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_busy_low: busy still 1 after 40 cycles, expected 0");
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        en = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
    endtask

    // Bus agent: acks in the ack_at-th cycle bus_req is high; ack_at of 0 never acks.
    initial begin
        int req_count;
        req_count = 0;
        forever begin
            @(negedge clk);
            if (!reset || !bus_req) begin
                req_count = 0;
                agent_ack = 1'b0;
            end else begin
                req_count++;
                agent_ack = (ack_at != 0) && (req_count == ack_at);
            end
        end
    end

    initial begin
        bit        prev_req;
        bit        prev_busy;
        bit        prev_fault;
        int        req_len;
        int        busy_len;
        bus_exp_t  cur;
        resp_exp_t rsp;
        prev_req = 0;
        prev_busy = 0;
        prev_fault = 0;
        req_len = 0;
        busy_len = 0;
        cur.req_len = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 0;
                prev_busy = 0;
                prev_fault = 0;
                req_len = 0;
                busy_len = 0;
                cur.req_len = 0;
            end else begin
                if (bus_req && !prev_req) begin
                    req_len = 1;
                    if (bus_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        cur.req_len = 0;
                        $display("[TB] FAIL unexpected_bus_req: bus_req=1 addr=0x%08h, expected no request", 32'(bus_addr));
                    end else begin
                        cur = bus_q.pop_front();
                        checkOutput("bus_we", 32'(bus_we), 32'(cur.we));
                        checkOutput("bus_addr", 32'(bus_addr), 32'(cur.baddr));
                        checkOutput("bus_be", 32'(bus_be), 32'(cur.be));
                        checkOutput("bus_wdata", bus_wdata, cur.wd);
                    end
                end else if (bus_req) begin
                    req_len++;
                end
                if (!bus_req && prev_req && cur.req_len > 0) begin
                    checkOutput("bus_req_len", 32'(req_len), 32'(cur.req_len));
                end
                if (busy) busy_len++;
                if ((prev_busy && !busy) || (fault && !prev_fault)) begin
                    if (resp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_completion: rdata=0x%08h fault=%0d, expected none", rdata, fault);
                    end else begin
                        rsp = resp_q.pop_front();
                        checkOutput("rdata", rdata, rsp.rd);
                        checkOutput("fault", 32'(fault), 32'(rsp.flt));
                        checkOutput("busy_len", 32'(busy_len), 32'(rsp.busy_len));
                    end
                    busy_len = 0;
                end
                prev_req = bus_req;
                prev_busy = busy;
                prev_fault = fault;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_watchdog: simulation time 200000 reached, expected finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bus_be", 32'(bus_be), 32'd0);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
        reset = 1'b1;
        @(posedge clk);

        $display("[TB] word load, ack in third request cycle");
        expectBus(1'b0, 30'h40, 4'b1111, 32'h0, 3);
        expectResp(32'hDEADBEEF, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, WIDTH_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 1'b0);

        $display("[TB] byte loads, sign and zero extended");
        expectBus(1'b0, 30'h40, 4'b1000, 32'h0, 1);
        expectResp(32'hFFFFFF80, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, WIDTH_BYTE, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 1'b0);
        expectBus(1'b0, 30'h40, 4'b1000, 32'h0, 2);
        expectResp(32'h00000080, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, WIDTH_BYTE, 32'h103, 32'h0, 32'h80FF1234, 2, 0, 1'b0);

        $display("[TB] half load, sign extended");
        expectBus(1'b0, 30'h40, 4'b1100, 32'h0, 1);
        expectResp(32'hFFFF80FF, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, WIDTH_HALF, 32'h102, 32'h0, 32'h80FF1234, 1, 0, 1'b0);

        $display("[TB] half store with en held in DONE");
        expectBus(1'b1, 30'h40, 4'b1100, 32'hABCDABCD, 1);
        expectResp(32'hFFFF80FF, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, WIDTH_HALF, 32'h102, 32'h0000ABCD, 32'h0, 1, 4, 1'b0);

        $display("[TB] byte store");
        expectBus(1'b1, 30'h40, 4'b0010, 32'h5A5A5A5A, 2);
        expectResp(32'hFFFF80FF, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, WIDTH_BYTE, 32'h101, 32'h0000005A, 32'h0, 2, 0, 1'b0);

        $display("[TB] stray ack in IDLE, then half load with en dropped during REQ");
        @(posedge clk); #1 stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        expectBus(1'b0, 30'h40, 4'b0011, 32'h0, 3);
        expectResp(32'hFFFFF00D, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, WIDTH_HALF, 32'h100, 32'h0, 32'h1234F00D, 3, 0, 1'b1);

        $display("[TB] word load at top of address space");
        expectBus(1'b0, 30'h3FFFFFFF, 4'b1111, 32'h0, 1);
        expectResp(32'h0BADCAFE, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, WIDTH_WORD, 32'hFFFFFFFC, 32'h0, 32'h0BADCAFE, 1, 0, 1'b0);

        $display("[TB] reset while bus_req is high");
        expectBus(1'b0, 30'h80, 4'b1111, 32'h0, 0);
        ack_at = 0;
        @(posedge clk); #1;
        write = 1'b0;
        width = WIDTH_WORD;
        addr = 32'h200;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_bus_req", 32'(bus_req), 32'd1);
        en = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("mid_rst_fault", 32'(fault), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        expectBus(1'b0, 30'h41, 4'b1111, 32'h0, 1);
        expectResp(32'h13579BDF, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, WIDTH_WORD, 32'h104, 32'h0, 32'h13579BDF, 1, 0, 1'b0);

        $display("[TB] misaligned word load faults, en then ignored");
        expectResp(32'h13579BDF, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, WIDTH_WORD, 32'h101, 32'h0, 32'h0, 1, 0, 1'b0);
        @(posedge clk); #1;
        width = WIDTH_WORD;
        addr = 32'h100;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("fault_busy", 32'(busy), 32'd0);
        checkOutput("fault_bus_req", 32'(bus_req), 32'd0);
        checkOutput("fault_sticky", 32'(fault), 32'd1);
        en = 1'b0;
        doReset();

        $display("[TB] illegal width faults");
        expectResp(32'h0, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 32'h0, 1, 0, 1'b0);
        doReset();

        $display("[TB] bus timeout with no ack");
        expectBus(1'b0, 30'hC0, 4'b1111, 32'h0, 4);
        expectResp(32'h0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, WIDTH_WORD, 32'h300, 32'h0, 32'h0, 0, 0, 1'b0);
        doReset();

        $display("[TB] ack in the final cycle before timeout");
        expectBus(1'b0, 30'hC0, 4'b1111, 32'h0, 4);
        expectResp(32'hCAFEF00D, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, WIDTH_WORD, 32'h300, 32'h0, 32'hCAFEF00D, 4, 0, 1'b0);

        repeat (4) @(posedge clk);
        checkOutput("bus_q_drained", 32'(bus_q.size()), 32'd0);
        checkOutput("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
